// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack CPU: opcodes, FSM states, fault codes and
// the per-opcode legality / pop / push tables used by the decode checks.
package stack_cpu_pkg;

   typedef enum logic [4:0] {
      OP_IMM  = 5'h01,
      OP_JMP  = 5'h06,
      OP_JZ   = 5'h07,
      OP_ADD  = 5'h0b,
      OP_SUB  = 5'h0c,
      OP_AND  = 5'h0d,
      OP_OR   = 5'h0e,
      OP_DUP  = 5'h10,
      OP_DROP = 5'h11,
      OP_NOP  = 5'h18,
      OP_HALT = 5'h1f
   } opcode_e;

   typedef enum logic [3:0] {
      FETCH, DECODE, OPND_REQ, OPND, RD_A, RD_B, WB, HALTED, ERROR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_ILLEGAL   = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_UNDERFLOW = 2'd3
   } err_e;

   // Tables are indexed by the low five opcode bits; 2 bits per entry for counts.
   localparam logic [31:0] OP_LEGAL =
      (32'h1 << OP_IMM) | (32'h1 << OP_JMP) | (32'h1 << OP_JZ)  | (32'h1 << OP_ADD) |
      (32'h1 << OP_SUB) | (32'h1 << OP_AND) | (32'h1 << OP_OR)  | (32'h1 << OP_DUP) |
      (32'h1 << OP_DROP) | (32'h1 << OP_NOP) | (32'h1 << OP_HALT);

   localparam logic [63:0] OP_POPS =
      (64'd1 << (2 * OP_JZ))  | (64'd2 << (2 * OP_ADD)) | (64'd2 << (2 * OP_SUB)) |
      (64'd2 << (2 * OP_AND)) | (64'd2 << (2 * OP_OR))  | (64'd1 << (2 * OP_DUP)) |
      (64'd1 << (2 * OP_DROP));

   localparam logic [63:0] OP_PUSHES =
      (64'd1 << (2 * OP_IMM)) | (64'd1 << (2 * OP_ADD)) | (64'd1 << (2 * OP_SUB)) |
      (64'd1 << (2 * OP_AND)) | (64'd1 << (2 * OP_OR))  | (64'd2 << (2 * OP_DUP));

   function automatic logic op_legal(input logic [4:0] op);
      return OP_LEGAL[op];
   endfunction

   function automatic logic [1:0] op_pops(input logic [4:0] op);
      return OP_POPS[{op, 1'b0} +: 2];
   endfunction

   function automatic logic [1:0] op_pushes(input logic [4:0] op);
      return OP_PUSHES[{op, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational two-operand ALU: y = a op b, where a is NOS and b is TOS.
module stack_cpu_alu
   import stack_cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  opcode_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = a_i + b_i;
      case (op_i)
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         default: y_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/stack_cpu_core.sv
// Stack-machine core between instruction ROM and stack RAM (both 1-cycle read latency).
// Define STACK_CPU_DBG_EN for registered dbg_* mirrors; otherwise dbg_* read 0.
module stack_cpu_core
   import stack_cpu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 256,
   parameter int RESET_PC    = 0
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_q,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_data,
   output logic              halted,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] dbg_pc,
   output logic [ADDR_W-1:0] dbg_sp,
   output logic [DATA_W-1:0] dbg_state,
   output logic [DATA_W-1:0] dbg_opcode
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(STACK_DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d;
   opcode_e           opcode_q, opcode_d;
   logic [DATA_W-1:0] a_q, a_d, wdata_q, wdata_d, alu_y;
   err_e              err_q, err_d;

   opcode_e           dec_op;
   logic              dec_legal;
   logic [1:0]        dec_pops, dec_pushes;
   logic [ADDR_W:0]   depth_after;

   assign dec_op      = opcode_e'(rom_q[4:0]);
   assign dec_legal   = (rom_q[DATA_W-1:5] == '0) && op_legal(rom_q[4:0]);
   assign dec_pops    = op_pops(rom_q[4:0]);
   assign dec_pushes  = op_pushes(rom_q[4:0]);
   assign depth_after = {1'b0, sp_q} - (ADDR_W+1)'(dec_pops) + (ADDR_W+1)'(dec_pushes);

   stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i (opcode_q),
      .a_i  (ram_q),
      .b_i  (a_q),
      .y_o  (alu_y)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      sp_d     = sp_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      err_d    = err_q;
      wdata_d  = wdata_q;
      rom_addr = pc_q;
      ram_addr = sp_q;
      ram_wren = 1'b0;
      ram_data = wdata_q;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            opcode_d = dec_op;
            if (!dec_legal) begin
               state_d = ERROR;
               err_d   = ERR_ILLEGAL;
            end else if (sp_q < ADDR_W'(dec_pops)) begin
               state_d = ERROR;
               err_d   = ERR_UNDERFLOW;
            end else if (depth_after > DEPTH_LIM) begin
               state_d = ERROR;
               err_d   = ERR_OVERFLOW;
            end else begin
               case (dec_op)
                  OP_NOP: begin
                     pc_d    = pc_q + ADDR_W'(1);
                     state_d = FETCH;
                  end
                  OP_HALT: state_d = HALTED;
                  OP_DROP: begin
                     sp_d    = sp_q - ADDR_W'(1);
                     pc_d    = pc_q + ADDR_W'(1);
                     state_d = FETCH;
                  end
                  OP_JMP, OP_JZ, OP_IMM: state_d = OPND_REQ;
                  default: state_d = RD_A;
               endcase
            end
         end
         OPND_REQ: begin
            // Operand word and (for JZ) TOS are requested together.
            rom_addr = pc_q + ADDR_W'(1);
            ram_addr = sp_q - ADDR_W'(1);
            state_d  = OPND;
         end
         OPND: begin
            state_d = FETCH;
            case (opcode_q)
               OP_JMP: pc_d = ADDR_W'(rom_q);
               OP_JZ: begin
                  sp_d = sp_q - ADDR_W'(1);
                  pc_d = (ram_q == '0) ? ADDR_W'(rom_q) : pc_q + ADDR_W'(2);
               end
               default: begin
                  ram_addr = sp_q;
                  ram_wren = 1'b1;
                  ram_data = rom_q;
                  wdata_d  = rom_q;
                  sp_d     = sp_q + ADDR_W'(1);
                  pc_d     = pc_q + ADDR_W'(2);
               end
            endcase
         end
         RD_A: begin
            ram_addr = sp_q - ADDR_W'(1);
            state_d  = (opcode_q == OP_DUP) ? WB : RD_B;
         end
         RD_B: begin
            a_d      = ram_q;
            ram_addr = sp_q - ADDR_W'(2);
            state_d  = WB;
         end
         WB: begin
            ram_wren = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
            state_d  = FETCH;
            if (opcode_q == OP_DUP) begin
               ram_addr = sp_q;
               ram_data = ram_q;
               sp_d     = sp_q + ADDR_W'(1);
            end else begin
               ram_addr = sp_q - ADDR_W'(2);
               ram_data = alu_y;
               sp_d     = sp_q - ADDR_W'(1);
            end
            wdata_d = ram_data;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= FETCH;
         pc_q     <= ADDR_W'(RESET_PC);
         sp_q     <= '0;
         opcode_q <= opcode_e'(5'h00);
         a_q      <= '0;
         wdata_q  <= '0;
         err_q    <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         sp_q     <= sp_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   assign halted   = (state_q == HALTED);
   assign error    = (state_q == ERROR);
   assign err_code = err_q;

`ifdef STACK_CPU_DBG_EN
   logic [ADDR_W-1:0] dbg_pc_q, dbg_sp_q;
   logic [DATA_W-1:0] dbg_state_q, dbg_opcode_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_pc_q     <= '0;
         dbg_sp_q     <= '0;
         dbg_state_q  <= '0;
         dbg_opcode_q <= '0;
      end else begin
         dbg_pc_q     <= pc_q;
         dbg_sp_q     <= sp_q;
         dbg_state_q  <= DATA_W'(state_q);
         dbg_opcode_q <= DATA_W'(opcode_q);
      end
   end

   assign dbg_pc     = dbg_pc_q;
   assign dbg_sp     = dbg_sp_q;
   assign dbg_state  = dbg_state_q;
   assign dbg_opcode = dbg_opcode_q;
`else
   assign dbg_pc     = '0;
   assign dbg_sp     = '0;
   assign dbg_state  = '0;
   assign dbg_opcode = '0;
`endif

endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: instruction-level reference model expands each
// instruction into expected per-cycle outputs; one negedge process compares.
module tb_stack_cpu_core;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] rom_addr, ram_addr, dbg_pc, dbg_sp;
   logic [DW-1:0] rom_q, ram_q, ram_data, dbg_state, dbg_opcode;
   logic          ram_wren, halted, error;
   logic [1:0]    err_code;

   logic [DW-1:0] rom_mem [0:65535];
   logic [DW-1:0] ram_mem [0:65535];
   logic [DW-1:0] mram    [0:31];

   typedef struct packed {
      logic          chk_rom;
      logic [AW-1:0] pc;
      logic          wren;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          halted;
      logic          error;
      logic [1:0]    err;
   } cyc_t;

   cyc_t exp_q[$];
   cyc_t cur;
   bit   run_active = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   mdl_pc, mdl_sp, mdl_err, mdl_done_cycle;
   bit   mdl_halt;

   stack_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clock      (clock),
      .reset      (reset),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .ram_addr   (ram_addr),
      .ram_q      (ram_q),
      .ram_wren   (ram_wren),
      .ram_data   (ram_data),
      .halted     (halted),
      .error      (error),
      .err_code   (err_code),
      .dbg_pc     (dbg_pc),
      .dbg_sp     (dbg_sp),
      .dbg_state  (dbg_state),
      .dbg_opcode (dbg_opcode)
   );

   // clock / memories
   always #5 clock = ~clock;

   always @(posedge clock) rom_q <= rom_mem[rom_addr];

   always @(posedge clock) begin
      ram_q <= ram_mem[ram_addr];
      if (ram_wren) ram_mem[ram_addr] = ram_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void emit(input bit chk, input int pc, input bit wr, input int wa,
                                input logic [DW-1:0] wd, input bit h, input int err);
      cyc_t e;
      e.chk_rom = chk;
      e.pc      = AW'(pc);
      e.wren    = wr;
      e.waddr   = AW'(wa);
      e.wdata   = wd;
      e.halted  = h;
      e.error   = (err != 0);
      e.err     = 2'(err);
      exp_q.push_back(e);
   endfunction

   // reference model: interpret the program one instruction at a time
   task automatic model_build(input int max_instr);
      int pc, sp;
      bit done;
      pc = 0; sp = 0; done = 1'b0;
      mdl_err = 0; mdl_halt = 1'b0; mdl_done_cycle = -1;
      exp_q.delete();
      for (int n = 0; n < max_instr && !done; n++) begin
         logic [DW-1:0] op, opnd, tos, nos, res;
         int  pops, pushes, ncyc, waddr;
         bit  legal, wr;
         op = rom_mem[pc];
         opnd = rom_mem[(pc + 1) % 65536];
         legal = 1'b1; pops = 0; pushes = 0; ncyc = 2; wr = 1'b0; waddr = 0; res = '0;
         case (op)
            16'h0018, 16'h001f: ;
            16'h0006: ncyc = 4;
            16'h0007: begin pops = 1; ncyc = 4; end
            16'h0001: begin pushes = 1; ncyc = 4; end
            16'h000b, 16'h000c, 16'h000d, 16'h000e: begin pops = 2; pushes = 1; ncyc = 5; end
            16'h0010: begin pops = 1; pushes = 2; ncyc = 4; end
            16'h0011: pops = 1;
            default: legal = 1'b0;
         endcase
         emit(1'b1, pc, 1'b0, 0, '0, 1'b0, 0);
         if (!legal || sp < pops || sp - pops + pushes > DEPTH) begin
            mdl_err = !legal ? 1 : (sp < pops) ? 3 : 2;
            emit(1'b0, 0, 1'b0, 0, '0, 1'b0, 0);
            done = 1'b1;
         end else begin
            case (op)
               16'h001f: begin mdl_halt = 1'b1; done = 1'b1; end
               16'h0006: pc = int'(opnd);
               16'h0007: begin
                  tos = mram[sp - 1];
                  sp = sp - 1;
                  pc = (tos == 0) ? int'(opnd) : (pc + 2) % 65536;
               end
               16'h0001: begin
                  wr = 1'b1; waddr = sp; res = opnd;
                  sp = sp + 1; pc = (pc + 2) % 65536;
               end
               16'h0010: begin
                  wr = 1'b1; waddr = sp; res = mram[sp - 1];
                  sp = sp + 1; pc = (pc + 1) % 65536;
               end
               16'h0011: begin sp = sp - 1; pc = (pc + 1) % 65536; end
               16'h0018: pc = (pc + 1) % 65536;
               default: begin
                  tos = mram[sp - 1];
                  nos = mram[sp - 2];
                  case (op)
                     16'h000b: res = nos + tos;
                     16'h000c: res = nos - tos;
                     16'h000d: res = nos & tos;
                     default:  res = nos | tos;
                  endcase
                  wr = 1'b1; waddr = sp - 2;
                  sp = sp - 1; pc = (pc + 1) % 65536;
               end
            endcase
            for (int c = 1; c < ncyc; c++)
               emit(1'b0, 0, wr && (c == ncyc - 1), waddr, res, 1'b0, 0);
            if (wr) mram[waddr] = res;
         end
      end
      if (done) begin
         mdl_done_cycle = exp_q.size();
         repeat (3) emit(1'b1, pc, 1'b0, 0, '0, mdl_halt, mdl_err);
      end
      mdl_pc = pc;
      mdl_sp = sp;
   endtask

   // per-cycle compare against the model's expected queue
   always @(negedge clock) begin
      if (run_active && exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("ram_wren", 32'(ram_wren), 32'(cur.wren));
         if (cur.wren) begin
            check("ram_addr", 32'(ram_addr), 32'(cur.waddr));
            check("ram_data", 32'(ram_data), 32'(cur.wdata));
         end
         if (cur.chk_rom) check("rom_addr", 32'(rom_addr), 32'(cur.pc));
         check("halted", 32'(halted), 32'(cur.halted));
         check("error", 32'(error), 32'(cur.error));
         check("err_code", 32'(err_code), 32'(cur.err));
`ifndef STACK_CPU_DBG_EN
         check("dbg_zero", 32'(dbg_pc | dbg_sp | dbg_state | dbg_opcode), 32'd0);
`endif
      end
   end

   // driver tasks
   task automatic check_reset_outputs();
      check("rst rom_addr", 32'(rom_addr), 32'd0);
      check("rst ram_addr", 32'(ram_addr), 32'd0);
      check("rst ram_wren", 32'(ram_wren), 32'd0);
      check("rst ram_data", 32'(ram_data), 32'd0);
      check("rst flags", 32'({halted, error, err_code}), 32'd0);
      check("rst dbg", 32'(dbg_pc | dbg_sp | dbg_state | dbg_opcode), 32'd0);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom_mem[i] = '0;
   endtask

   task automatic run_test(input int max_instr);
      int bound;
      for (int i = 0; i < 32; i++) begin
         logic [DW-1:0] v;
         v = DW'($urandom);
         ram_mem[i] = v;
         mram[i] = v;
      end
      model_build(max_instr);
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      run_active = 1'b1;
      bound = exp_q.size() + 20;
      for (int c = 0; c < bound && exp_q.size() > 0; c++) begin
         @(negedge clock);
         #2;
      end
      check("queue drained", 32'(exp_q.size()), 32'd0);
      run_active = 1'b0;
      exp_q.delete();
   endtask

   task automatic end_test();
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i <= DEPTH; i++) check("ram contents", 32'(ram_mem[i]), 32'(mram[i]));
   endtask

   task automatic gen_random_prog();
      int a;
      clear_rom();
      a = 0;
      while (a < 48) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 24) begin
            rom_mem[a] = 16'h0001;
            rom_mem[a + 1] = ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom);
            a += 2;
         end else if (r < 36) begin
            rom_mem[a] = DW'(16'h000b + $urandom_range(0, 3)); a++;
         end else if (r < 46) begin
            rom_mem[a] = 16'h0010; a++;
         end else if (r < 54) begin
            rom_mem[a] = 16'h0011; a++;
         end else if (r < 61) begin
            rom_mem[a] = 16'h0018; a++;
         end else if (r < 73) begin
            rom_mem[a] = 16'h0007;
            rom_mem[a + 1] = DW'($urandom_range(0, 47));
            a += 2;
         end else if (r < 77) begin
            rom_mem[a] = 16'h0006;
            rom_mem[a + 1] = DW'($urandom_range(0, 47));
            a += 2;
         end else if (r < 80) begin
            rom_mem[a] = 16'h001f; a++;
         end else if (r < 83) begin
            rom_mem[a] = DW'($urandom); a++;
         end else begin
            rom_mem[a] = 16'h0018; a++;
         end
      end
      rom_mem[a] = 16'h001f;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         rom_mem[i] = '0;
         ram_mem[i] = '0;
      end
      repeat (2) @(posedge clock);

      // IMM 3, IMM 4, ADD, HALT
      clear_rom();
      rom_mem[0] = 16'h0001; rom_mem[1] = 16'h0003; rom_mem[2] = 16'h0001; rom_mem[3] = 16'h0004;
      rom_mem[4] = 16'h000b; rom_mem[5] = 16'h001f;
      run_test(50);
      check("t1 halt cycle", 32'(mdl_done_cycle), 32'd15);
      check("t1 ram0", 32'(ram_mem[0]), 32'h7);
      check("t1 halted", 32'({halted, error}), 32'b10);
      end_test();

      // IMM 5, IMM 9, SUB, HALT
      clear_rom();
      rom_mem[0] = 16'h0001; rom_mem[1] = 16'h0005; rom_mem[2] = 16'h0001; rom_mem[3] = 16'h0009;
      rom_mem[4] = 16'h000c; rom_mem[5] = 16'h001f;
      run_test(50);
      check("t2 ram0", 32'(ram_mem[0]), 32'hfffc);
      end_test();

      // JZ taken and not taken
      clear_rom();
      rom_mem[0] = 16'h0001; rom_mem[1] = 16'h0000; rom_mem[2] = 16'h0007; rom_mem[3] = 16'h0020;
      rom_mem[4] = 16'h001f; rom_mem[32] = 16'h001f;
      run_test(50);
      check("t3 taken pc", 32'(rom_addr), 32'h20);
      check("t3 model pc", 32'(mdl_pc), 32'h20);
      check("t3 model sp", 32'(mdl_sp), 32'd0);
      end_test();
      rom_mem[1] = 16'h0001;
      run_test(50);
      check("t3 fall pc", 32'(rom_addr), 32'h4);
      check("t3 halted", 32'(halted), 32'd1);
      end_test();

      // overflow: push in a loop until the stack is full
      clear_rom();
      rom_mem[0] = 16'h0001; rom_mem[1] = 16'ha5a5; rom_mem[2] = 16'h0006; rom_mem[3] = 16'h0000;
      run_test(100);
      check("t4 err_code", 32'(err_code), 32'd2);
      check("t4 error", 32'(error), 32'd1);
      check("t4 model sp", 32'(mdl_sp), 32'(DEPTH));
      check("t4 rom_addr", 32'(rom_addr), 32'd0);
      end_test();

      // underflow and illegal opcodes at reset
      clear_rom();
      rom_mem[0] = 16'h000b;
      run_test(10);
      check("t5 underflow", 32'(err_code), 32'd3);
      end_test();
      rom_mem[0] = 16'h0055;
      run_test(10);
      check("t5 illegal", 32'(err_code), 32'd1);
      end_test();
      rom_mem[0] = 16'h0118;
      run_test(10);
      check("t5 illegal hi", 32'(err_code), 32'd1);
      end_test();
      rom_mem[0] = 16'h0010;
      run_test(10);
      check("t5 dup underflow", 32'(err_code), 32'd3);
      end_test();

      // reset asserted during the ADD writeback
      clear_rom();
      rom_mem[0] = 16'h0001; rom_mem[1] = 16'h0003; rom_mem[2] = 16'h0001; rom_mem[3] = 16'h0004;
      rom_mem[4] = 16'h000b; rom_mem[5] = 16'h001f;
      run_test(2);
      repeat (5) @(negedge clock);
      check("t6 wb wren", 32'(ram_wren), 32'd1);
      check("t6 wb data", 32'(ram_data), 32'h7);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clock);
      #1;
      check("t6 ram0 kept", 32'(ram_mem[0]), 32'h3);
      check("t6 ram1 kept", 32'(ram_mem[1]), 32'h4);
      end_test();

      // randomized programs
      for (int t = 0; t < 20; t++) begin
         gen_random_prog();
         run_test(100);
         end_test();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

endmodule
